// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage for Rijndael states of NB = 4, 6 or 8 columns.
// The transform is applied before storage; a 2-entry buffer decouples in_ready from out_ready.
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_inv,
  input  logic [32*NB-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_inv,
  output logic [32*NB-1:0]    out_data,
  output logic [CNT_W-1:0]    blk_cnt
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_nb_check
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [W-1:0] shifted;

  // Each output byte picks its source column at elaboration time; only the
  // forward/inverse choice is left as a runtime mux.
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int OFF = (NB == 8 && r >= 2) ? r + 1 : r;
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int SRC_F = (c + OFF) % NB;
      localparam int SRC_I = (c + NB - OFF) % NB;
      assign shifted[W-1-(c*32+r*8) -: 8] = in_inv ? in_data[W-1-(SRC_I*32+r*8) -: 8]
                                                   : in_data[W-1-(SRC_F*32+r*8) -: 8];
    end
  end

  logic [1:0]   count;
  logic [W-1:0] data0, data1;
  logic         inv0, inv1;
  logic         push, pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = data0;
  assign out_inv   = inv0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Slot 0 is always the head, so the output mux is free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= 2'd0;
      data0   <= '0;
      data1   <= '0;
      inv0    <= 1'b0;
      inv1    <= 1'b0;
      blk_cnt <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (pop) blk_cnt <= blk_cnt + 1'b1;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            data0 <= shifted;
            inv0  <= in_inv;
          end else begin
            data1 <= shifted;
            inv1  <= in_inv;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          data0 <= data1;
          inv0  <= inv1;
          count <= count - 2'd1;
        end
        2'b11: begin
          data0 <= shifted;
          inv0  <= in_inv;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: NB=4/6/8 instances share handshake controls and are
// checked against a reference ShiftRows model through a scoreboard queue.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_inv, out_ready;
  logic [127:0] d4;
  logic [191:0] d6;
  logic [255:0] d8;

  logic         in_ready4, in_ready6, in_ready8;
  logic         out_valid4, out_valid6, out_valid8;
  logic         out_inv4, out_inv6, out_inv8;
  logic [127:0] od4;
  logic [191:0] od6;
  logic [255:0] od8;
  logic [15:0]  cnt4, cnt6;
  logic [3:0]   cnt8;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  shift_rows_pipe #(.NB(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_inv(in_inv), .in_data(d4), .out_valid(out_valid4), .out_ready(out_ready),
    .out_inv(out_inv4), .out_data(od4), .blk_cnt(cnt4));

  shift_rows_pipe #(.NB(6), .CNT_W(16)) dut6 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready6),
    .in_inv(in_inv), .in_data(d6), .out_valid(out_valid6), .out_ready(out_ready),
    .out_inv(out_inv6), .out_data(od6), .blk_cnt(cnt6));

  shift_rows_pipe #(.NB(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready8),
    .in_inv(in_inv), .in_data(d8), .out_valid(out_valid8), .out_ready(out_ready),
    .out_inv(out_inv8), .out_data(od8), .blk_cnt(cnt8));

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input bit inv);
    logic [255:0] o;
    int offs8[4];
    int w, off, src;
    offs8 = '{0, 1, 3, 4};
    o = '0;
    w = 32 * nb;
    for (int r = 0; r < 4; r++) begin
      off = (nb == 8) ? offs8[r] : r;
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - off + nb) % nb : (c + off) % nb;
        o[w-1-(c*32+r*8) -: 8] = d[w-1-(src*32+r*8) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [255:0] pat(input int nb);
    logic [255:0] o;
    int w;
    o = '0;
    w = 32 * nb;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++)
        o[w-1-(c*32+r*8) -: 8] = 8'((r << 6) | c);
    return o;
  endfunction

  typedef struct {
    logic [127:0] e4;
    logic [191:0] e6;
    logic [255:0] e8;
    logic         inv;
  } exp_t;
  exp_t sbq[$];

  // Scoreboard: handshakes are stable at the falling edge and fire at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || flush) begin
      sbq.delete();
    end else begin
      if (out_valid4 && out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_pop", 256'(out_valid4), 256'(0));
        end else begin
          e = sbq.pop_front();
          chk("sb_data4", 256'(od4), 256'(e.e4));
          chk("sb_inv4", 256'(out_inv4), 256'(e.inv));
          chk("sb_data6", 256'(od6), 256'(e.e6));
          chk("sb_data8", od8, e.e8);
          chk("sb_inv8", 256'(out_inv8), 256'(e.inv));
        end
      end
      if (in_valid && in_ready4) begin
        e.e4  = 128'(ref_shift(256'(d4), 4, in_inv));
        e.e6  = 192'(ref_shift(256'(d6), 6, in_inv));
        e.e8  = ref_shift(d8, 8, in_inv);
        e.inv = in_inv;
        sbq.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && out_valid4; i++) tick();
    chk("drain_empty", 256'(out_valid4), 256'(0));
  endtask

  typedef struct {
    logic         inv;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs[4];

  initial begin
    logic [127:0] a_exp, b_exp, c_exp;
    logic [191:0] r6;
    logic [255:0] r8;
    logic [15:0]  c0;
    int stalls;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0;
    d4 = '0; d6 = '0; d8 = '0;

    vecs[0] = '{1'b0, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
    vecs[1] = '{1'b1, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230};
    vecs[2] = '{1'b0, 128'h004080c0_014181c1_024282c2_034383c3, 128'h004182c3_014283c0_024380c1_034081c2};
    vecs[3] = '{1'b1, 128'h004080c0_014181c1_024282c2_034383c3, 128'h004382c1_014083c2_024180c3_034281c0};

    tick(); tick();
    rst_n = 1'b1;
    chk("rst_out_valid", 256'(out_valid4), 256'(0));
    chk("rst_in_ready", 256'(in_ready4), 256'(1));
    chk("rst_out_data", 256'(od4), 256'(0));
    chk("rst_out_inv", 256'(out_inv4), 256'(0));
    chk("rst_blk_cnt", 256'(cnt4), 256'(0));

    // NB=4 known vectors, one-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d4 = vecs[i].din; in_inv = vecs[i].inv; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("vec_valid", 256'(out_valid4), 256'(1));
      chk("vec_data", 256'(od4), 256'(vecs[i].exp));
      chk("vec_inv", 256'(out_inv4), 256'(vecs[i].inv));
      tick();
    end

    // NB=6 / NB=8 pattern forward, then inverse round trip
    d4 = '0; d6 = 192'(pat(6)); d8 = pat(8); in_inv = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    r6 = od6; r8 = od8;
    chk("nb6_fwd", 256'(od6), ref_shift(pat(6), 6, 1'b0));
    chk("nb8_fwd", od8, ref_shift(pat(8), 8, 1'b0));
    chk("nb8_row3_byte", 256'(od8[255-(0*32+3*8) -: 8]), 256'(8'hc4));
    tick();
    d6 = r6; d8 = r8; in_inv = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("nb6_roundtrip", 256'(od6), pat(6));
    chk("nb8_roundtrip", od8, pat(8));
    chk("nb8_inv_tag", 256'(out_inv8), 256'(1));
    drain();

    // Back-pressure: A, B accepted, C held
    do_reset();
    out_ready = 1'b0; in_inv = 1'b0;
    d4 = 128'h000102030405060708090a0b0c0d0e0f; in_valid = 1'b1;
    a_exp = 128'(ref_shift(256'(d4), 4, 1'b0));
    tick();
    chk("bp_ready_after_a", 256'(in_ready4), 256'(1));
    d4 = 128'h101112131415161718191a1b1c1d1e1f; in_inv = 1'b1;
    b_exp = 128'(ref_shift(256'(d4), 4, 1'b1));
    tick();
    chk("bp_ready_after_b", 256'(in_ready4), 256'(0));
    d4 = 128'h202122232425262728292a2b2c2d2e2f; in_inv = 1'b0;
    c_exp = 128'(ref_shift(256'(d4), 4, 1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_ready", 256'(in_ready4), 256'(0));
      chk("bp_hold_data", 256'(od4), 256'(a_exp));
      chk("bp_hold_inv", 256'(out_inv4), 256'(0));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_rel_b", 256'(od4), 256'(b_exp));
    chk("bp_rel_b_inv", 256'(out_inv4), 256'(1));
    tick();
    in_valid = 1'b0;
    chk("bp_rel_c", 256'(od4), 256'(c_exp));
    tick();
    chk("bp_empty", 256'(out_valid4), 256'(0));
    chk("bp_blk_cnt", 256'(cnt4), 256'(3));

    // Streaming with alternating mode
    c0 = cnt4;
    stalls = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d4 = {$urandom, $urandom, $urandom, $urandom};
      d6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      d8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in_inv = i[0]; in_valid = 1'b1;
      tick();
      if (!in_ready4 || !out_valid4) stalls++;
    end
    drain();
    chk("stream_stalls", 256'(stalls), 256'(0));
    chk("stream_blk_cnt", 256'(cnt4 - c0), 256'(100));
    chk("stream_sb_empty", 256'(sbq.size()), 256'(0));

    // Flush with count = 2; blk_cnt retained
    out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0;
    tick(); tick();
    chk("fl_full", 256'(in_ready4), 256'(0));
    c0 = cnt4;
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("fl_out_valid", 256'(out_valid4), 256'(0));
    chk("fl_in_ready", 256'(in_ready4), 256'(1));
    chk("fl_blk_cnt", 256'(cnt4), 256'(c0));

    // Refill, then reset mid-operation (reset wins over flush)
    in_valid = 1'b1; in_inv = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    chk("rf_full", 256'(in_ready4), 256'(0));
    rst_n = 1'b0; flush = 1'b1;
    tick();
    rst_n = 1'b1; flush = 1'b0;
    chk("mrst_out_valid", 256'(out_valid4), 256'(0));
    chk("mrst_in_ready", 256'(in_ready4), 256'(1));
    chk("mrst_out_data", 256'(od4), 256'(0));
    chk("mrst_out_inv", 256'(out_inv4), 256'(0));
    chk("mrst_blk_cnt", 256'(cnt4), 256'(0));
    chk("mrst_blk_cnt8", 256'(cnt8), 256'(0));

    // CNT_W=4 wrap on the NB=8 instance
    out_ready = 1'b1; in_valid = 1'b1; in_inv = 1'b0;
    for (int i = 0; i < 15; i++) begin
      d8 = {8{$urandom}};
      tick();
    end
    drain();
    chk("wrap_pre", 256'(cnt8), 256'(15));
    in_valid = 1'b1;
    tick();
    drain();
    chk("wrap_post", 256'(cnt8), 256'(0));
    chk("wrap_cnt4", 256'(cnt4), 256'(16));
    chk("end_sb_empty", 256'(sbq.size()), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
# shift_rows_pipe

Parametrised, registered ShiftRows / InvShiftRows stage for the AES/Rijndael datapath. It supports Rijndael block widths of Nb = 4, 6 or 8 columns and selects forward or inverse shifting per block. Blocks move through a valid/ready handshake with a 2-entry output buffer, so the stage sustains one block per cycle and absorbs downstream back-pressure. It sits between the SubBytes and MixColumns stages in the round pipeline, and the inverse mode serves the decrypt path.

## Interface
- NB, default 4: state columns; legal values 4, 6, 8; any other value is an elaboration `$error`.
- CNT_W, default 16: width of the delivered-block counter.
- W (derived, not overridable): 32*NB, the state width in bits.

- clk  in  1  rising-edge clock; the block has one clock.
- rst_n  in  1  reset; synchronous and active-low.
- flush  in  1  synchronous clear of buffered blocks; counter is kept.
- in_valid  in  1  in_data / in_inv are valid.
- in_ready  out  1  stage can accept a block.
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows.
- in_data  in  W  input state.
- out_valid  out  1  out_data / out_inv are valid.
- out_ready  in  1  downstream accepts.
- out_inv  out  1  mode tag echoed with the block.
- out_data  out  W  shifted state.
- blk_cnt  out  CNT_W  count of blocks delivered (out_valid & out_ready).

## Operation
- Byte mapping is column-major, MSB-first:
  - byte(r,c) = data[W-1-(c*32+r*8) -: 8], with r in 0..3 and c in 0..NB-1.
  - Byte 0 (r0,c0) occupies the top 8 bits.
- Row offsets C_r for rows 0..3:
  - NB=4: 0,1,2,3.
  - NB=6: 0,1,2,3.
  - NB=8: 0,1,3,4.
- Forward mode: out(r,c) = in(r,(c+C_r) mod NB).
- Inverse mode: out(r,c) = in(r,(c-C_r+NB) mod NB).
- The transform is applied combinationally at the buffer input. Only transformed data and its inv tag are stored.
- Buffer: 2-entry FIFO with occupancy count in 0..2.
  - Push when in_valid & in_ready.
  - Pop when out_valid & out_ready.
- Outputs are driven from buffer state only:
  - in_ready = (count != 2). It depends on registered state only, with no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_data / out_inv = head entry.
- Occupancy update:
  - Push with no pop: count+1.
  - Pop with no push: count-1.
  - Push and pop together (count = 1): count stays 1. The head becomes the new block and output order is preserved.
  - count = 2: in_ready = 0, so no push; a pop that cycle takes count to 1.
- Every stored entry is held stable until popped:
  - out_data and out_inv must not change while out_valid = 1 and out_ready = 0.
- blk_cnt increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- flush = 1 at a clock edge:
  - count -> 0 and the contents are discarded.
  - Any push or pop in that same cycle is ignored.
  - blk_cnt is not incremented and not cleared.
- Mode may change on every block; there is no global mode state.

## Timing
- Reset (rst_n = 0 at an edge) sets count = 0, blk_cnt = 0, out_valid = 0, in_ready = 1 and out_data = 0, out_inv = 0.
  - Outputs take these values in the cycle after the edge.
  - Reset mid-operation discards buffered blocks. Reset has priority over flush.
- Latency: a block accepted at edge k, with the buffer empty, appears with out_valid = 1 after edge k, i.e. 1 cycle.
- Throughput: with out_ready held at 1, the stage accepts and delivers one block per cycle indefinitely at count = 1.
- Back-pressure:
  - With out_ready = 0, two blocks are accepted; then in_ready = 0 from the cycle after the second accept.
  - When out_ready returns, blocks are delivered in acceptance order on consecutive cycles.

## Test plan
- NB=4 forward vector (FIPS-197 App. B, round 1):
  - in = d42711ae_e0bf98f1_b8b45de5_1e415230, inv=0.
  - Expect out = d4bf5d30_e0b452ae_b84111f1_1e2798e5, out_inv=0, one cycle later.
- NB=4 inverse vector:
  - in = d4bf5d30_e0b452ae_b84111f1_1e2798e5, inv=1.
  - Expect d42711ae_e0bf98f1_b8b45de5_1e415230, out_inv=1.
- NB=6 and NB=8 forward:
  - Input byte(r,c) = {r[1:0], c[5:0]}.
  - Expect out byte(r,c) = {r, (c+C_r) mod NB}; for NB=8 this exercises row offsets 3 and 4.
  - Inverse of each result returns the original input.
- Back-pressure:
  - Hold out_ready=0 and offer blocks A, B, C with in_valid=1.
  - Expect A and B accepted, in_ready=0, C held, outputs stable.
  - Release out_ready: A, B, C delivered on consecutive cycles; blk_cnt = 3.
- Streaming with alternating inv:
  - Stream 100 random blocks with alternating inv and out_ready=1.
  - Expect zero stall cycles, output order and tag preserved, every result matching the reference model.
- Flush / reset mid-operation:
  - Fill to count=2, then assert flush: out_valid=0 and in_ready=1 next cycle, blk_cnt unchanged.
  - Refill, then assert rst_n=0 for one edge: all outputs at reset values and blk_cnt = 0.
  - Start CNT_W=4 at blk_cnt=15 and deliver one block: blk_cnt wraps to 0.
